ysyx_25030093_ifu: RTL and testbench

Instruction fetch unit for the multi-cycle NPC core. It is the producer side of the fetch→decode valid/ready handshake. It holds the PC and issues a single-beat read on an AXI-lite-style read channel. It presents the fetched word and its PC to the decode unit, then waits for the next PC from write-back before starting the next fetch.

---
 rtl/ysyx_25030093_ifu.sv | 99 +++++++++
 tb/tb_ysyx_25030093_ifu.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: holds the PC, issues one AXI-lite read per
// instruction and hands the fetched word to decode over valid/ready.
module ysyx_25030093_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic              out_valid,
  input  logic              in_ready,
  input  logic              npc_valid,
  input  logic [ADDR_W-1:0] dnpc,
  output logic              fetch_err,
  output logic [31:0]       inst_cnt
);

  typedef enum logic [2:0] {
    AR,
    R,
    HOLD,
    WAIT_PC,
    ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic              r_run;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic [31:0]       r_cnt;
  logic              r_err;

  logic w_ar_go;
  logic w_rd_ok;
  logic w_rd_bad;
  logic w_take;
  logic w_pc_ok;
  logic w_pc_bad;

  // r_run keeps the bus quiet for the cycle in which reset is still high
  assign w_ar_go  = (r_state == AR) && r_run && arready;
  assign w_rd_ok  = (r_state == R) && rvalid && (rresp == 2'b00);
  assign w_rd_bad = (r_state == R) && rvalid && (rresp != 2'b00);
  assign w_take   = (r_state == HOLD) && in_ready;
  assign w_pc_ok  = (r_state == WAIT_PC) && npc_valid
                    && (dnpc[1:0] == 2'b00);
  assign w_pc_bad = (r_state == WAIT_PC) && npc_valid
                    && (dnpc[1:0] != 2'b00);

  always_comb begin
    w_state_n = r_state;
    unique case (1'b1)
      w_ar_go:  w_state_n = R;
      w_rd_ok:  w_state_n = HOLD;
      w_rd_bad: w_state_n = ERR;
      w_take:   w_state_n = WAIT_PC;
      w_pc_ok:  w_state_n = AR;
      w_pc_bad: w_state_n = ERR;
      default:  w_state_n = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= AR;
      r_run   <= 1'b0;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_cnt   <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_run   <= 1'b1;
      if (w_rd_ok) r_inst <= rdata;
      if (w_pc_ok) r_pc <= dnpc;
      if (w_take) r_cnt <= r_cnt + 32'd1;
      if (w_rd_bad || w_pc_bad) r_err <= 1'b1;
    end
  end

  assign arvalid   = (r_state == AR) && r_run;
  assign araddr    = r_pc;
  assign rready    = (r_state == R);
  assign out_valid = (r_state == HOLD);
  assign inst      = r_inst;
  assign pc        = r_pc;
  assign fetch_err = r_err;
  assign inst_cnt  = r_cnt;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Scoreboard bench for the IFU: directed fetches push expected {pc,inst};
// a monitor pops and compares on every decode handshake.
module tb_ysyx_25030093_ifu;

  localparam logic [31:0] RST = 32'h8000_0000;

  logic        clock;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        out_valid;
  logic        in_ready;
  logic        npc_valid;
  logic [31:0] dnpc;
  logic        fetch_err;
  logic [31:0] inst_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 0;

  ysyx_25030093_ifu #(.ADDR_W(32), .RESET_PC(RST)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .out_valid(out_valid), .in_ready(in_ready),
    .npc_valid(npc_valid), .dnpc(dnpc),
    .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // inputs settle right after each negedge; the monitor looks 1 unit later
  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && in_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc", pc, e.pc);
        chk("mon_inst", inst, e.inst);
        chk("mon_cnt", inst_cnt, exp_cnt);
        exp_cnt = exp_cnt + 32'd1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; arready = 1'b0; rvalid = 1'b0;
    in_ready = 1'b0; npc_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, RST);
    chk("rst_cnt", inst_cnt, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clock);
    chk("rel_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rel_araddr", araddr, RST);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] resp, input int aw,
                          input int rw);
    int n;
    n = 0;
    while (!arvalid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("f_arvalid", {31'd0, arvalid}, 32'd1);
    chk("f_araddr", araddr, a);
    arready = 1'b0;
    repeat (aw) begin
      @(negedge clock);
      chk("f_ar_hold", {31'd0, arvalid}, 32'd1);
      chk("f_addr_hold", araddr, a);
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("f_rready", {31'd0, rready}, 32'd1);
    chk("f_no_ar", {31'd0, arvalid}, 32'd0);
    repeat (rw) begin
      @(negedge clock);
      chk("f_r_wait", {31'd0, rready}, 32'd1);
      chk("f_ov_wait", {31'd0, out_valid}, 32'd0);
    end
    rvalid = 1'b1; rdata = d; rresp = resp;
    if (resp == 2'b00) sb.push_back('{pc: a, inst: d});
    @(negedge clock);
    rvalid = 1'b0; rresp = 2'b00;
    if (resp == 2'b00) begin
      chk("f_out_valid", {31'd0, out_valid}, 32'd1);
      chk("f_inst", inst, d);
      chk("f_pc", pc, a);
    end else begin
      chk("f_err", {31'd0, fetch_err}, 32'd1);
      chk("f_err_ov", {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic decode(input int n, input logic [31:0] ei,
                        input logic [31:0] ep);
    in_ready = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk("d_ov_hold", {31'd0, out_valid}, 32'd1);
      chk("d_inst_hold", inst, ei);
      chk("d_pc_hold", pc, ep);
    end
    in_ready = 1'b1;
    @(negedge clock);
    in_ready = 1'b0;
    chk("d_ov_drop", {31'd0, out_valid}, 32'd0);
    chk("d_inst_keep", inst, ei);
    chk("d_no_ar", {31'd0, arvalid}, 32'd0);
  endtask

  task automatic give_npc(input logic [31:0] a);
    npc_valid = 1'b1; dnpc = a;
    @(negedge clock);
    npc_valid = 1'b0;
    chk("n_arvalid", {31'd0, arvalid}, 32'd1);
    chk("n_araddr", araddr, a);
  endtask

  initial begin
    int n;
    reset = 1'b1; arready = 1'b0; rdata = 32'h0; rresp = 2'b00;
    rvalid = 1'b0; in_ready = 1'b0; npc_valid = 1'b0; dnpc = 32'h0;

    // zero-wait first fetch
    do_reset();
    do_fetch(RST, 32'h0010_0093, 2'b00, 0, 0);
    decode(0, 32'h0010_0093, RST);
    chk("cnt_1", inst_cnt, 32'd1);
    give_npc(32'h8000_0004);

    // slow memory, then decode stalls 5 cycles
    do_fetch(32'h8000_0004, 32'h0020_8113, 2'b00, 3, 2);
    decode(5, 32'h0020_8113, 32'h8000_0004);
    chk("cnt_2", inst_cnt, 32'd2);
    give_npc(32'h8000_0008);

    // npc_valid during HOLD must be ignored
    do_fetch(32'h8000_0008, 32'h0031_0193, 2'b00, 0, 1);
    npc_valid = 1'b1; dnpc = 32'h8000_0200;
    repeat (2) @(negedge clock);
    npc_valid = 1'b0;
    chk("hold_pc", pc, 32'h8000_0008);
    decode(0, 32'h0031_0193, 32'h8000_0008);
    repeat (3) begin
      @(negedge clock);
      chk("wait_no_ar", {31'd0, arvalid}, 32'd0);
    end
    give_npc(32'h8000_0100);
    do_fetch(32'h8000_0100, 32'hfff0_0513, 2'b00, 1, 0);
    decode(1, 32'hfff0_0513, 32'h8000_0100);
    chk("cnt_4", inst_cnt, 32'd4);

    // bus fault on the data beat is terminal
    give_npc(32'h8000_0104);
    do_fetch(32'h8000_0104, 32'hdead_beef, 2'b10, 0, 0);
    chk("err_inst", inst, 32'hfff0_0513);
    n = 0;
    npc_valid = 1'b1; dnpc = 32'h8000_0000;
    repeat (20) begin
      @(negedge clock);
      if (arvalid || rready || out_valid) n++;
    end
    npc_valid = 1'b0;
    chk("err_quiet", n, 32'd0);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);

    // misaligned next PC
    do_reset();
    do_fetch(RST, 32'h0000_0013, 2'b00, 0, 0);
    decode(0, 32'h0000_0013, RST);
    npc_valid = 1'b1; dnpc = 32'h8000_0002;
    @(negedge clock);
    npc_valid = 1'b0;
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, RST);
    repeat (3) begin
      @(negedge clock);
      chk("mis_no_ar", {31'd0, arvalid}, 32'd0);
    end

    // reset while in R with a data beat in the same cycle
    do_reset();
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("mid_rready", {31'd0, rready}, 32'd1);
    reset = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
    @(negedge clock);
    rvalid = 1'b0;
    chk("mid_rready0", {31'd0, rready}, 32'd0);
    chk("mid_ov0", {31'd0, out_valid}, 32'd0);
    chk("mid_inst", inst, 32'd0);
    chk("mid_pc", pc, RST);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_arvalid", {31'd0, arvalid}, 32'd1);
    chk("mid_cnt", inst_cnt, 32'd0);
    chk("mid_err", {31'd0, fetch_err}, 32'd0);

    @(negedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
